subbytes_serial: RTL and testbench

SUBBYTES_SERIAL -- requirements
Module: subbytes_serial

---
 rtl/subbytes_serial_pkg.sv | 24 ++
 rtl/subbytes_serial_sbox.sv | 61 ++++++
 rtl/subbytes_serial.sv | 87 ++++++++
 tb/tb_subbytes_serial.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/subbytes_serial_pkg.sv
// Shared definitions for the serial SubBytes engine: block geometry, FSM
// encodings and the byte-index to bit-slice convention (byte 0 is the MSB).
package subbytes_serial_pkg;

  localparam int NUM_BYTES = 16;
  localparam int BLOCK_W   = 8 * NUM_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Lowest bit position of byte idx inside a block.
  function automatic int byte_lsb(input int idx);
    return BLOCK_W - 8 - 8 * idx;
  endfunction

  function automatic logic [7:0] get_byte(input logic [BLOCK_W-1:0] blk,
                                          input logic [3:0]         idx);
    return blk[byte_lsb(int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/subbytes_serial_sbox.sv
// Area-oriented AES S-box: GF(2^8) inversion by exponentiation plus the
// forward or inverse affine map, selected by encrypt.
module sbox_new_area (
  input  logic [7:0] byte_in,
  input  logic       encrypt,
  output logic [7:0] byte_out
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a240, a252;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a6   = gf_mul(a3, a3);
    a12  = gf_mul(a6, a6);
    a15  = gf_mul(a12, a3);
    a240 = a15;
    for (int i = 0; i < 4; i++) a240 = gf_mul(a240, a240);
    a252 = gf_mul(a240, a12);
    return gf_mul(a252, a2);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    logic [15:0] t;
    t = {a, a} << n;
    return t[15:8];
  endfunction

  logic [7:0] fwd_out;
  logic [7:0] inv_pre;
  logic [7:0] inv_out;

  always_comb begin
    fwd_out  = '0;
    inv_pre  = '0;
    inv_out  = '0;
    byte_out = '0;
    if (encrypt) begin
      fwd_out  = gf_inv(byte_in);
      byte_out = fwd_out ^ rotl(fwd_out, 1) ^ rotl(fwd_out, 2) ^
                 rotl(fwd_out, 3) ^ rotl(fwd_out, 4) ^ 8'h63;
    end else begin
      inv_pre  = rotl(byte_in, 1) ^ rotl(byte_in, 3) ^ rotl(byte_in, 6) ^ 8'h05;
      inv_out  = gf_inv(inv_pre);
      byte_out = inv_out;
    end
  end

endmodule

// File: rtl/subbytes_serial.sv
// Serial SubBytes: accepts a 128-bit state, substitutes one byte per clock
// through a single shared S-box, and holds the result until taken.
module subbytes_serial
  import subbytes_serial_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BLOCK_W-1:0]  state_in,
  input  logic                encrypt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BLOCK_W-1:0]  state_out,
  output logic                busy
);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 mode_q, mode_d;
  logic [BLOCK_W-1:0]   data_q, data_d;
  logic [NUM_BYTES-1:0] byte_en;
  logic [7:0]           sbox_in;
  logic [7:0]           sbox_out;

  assign sbox_in = get_byte(data_q, cnt_q);

  sbox_new_area u_sbox (
    .byte_in  (sbox_in),
    .encrypt  (mode_q),
    .byte_out (sbox_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    data_d  = data_q;
    byte_en = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = state_in;
          mode_d  = encrypt;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        byte_en[cnt_q] = 1'b1;
        // Counter parks at the last index instead of wrapping.
        if (cnt_q == 4'(NUM_BYTES - 1)) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (byte_en[i]) data_d[byte_lsb(i) +: 8] = sbox_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b1;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign state_out = data_q;

endmodule

// File: tb/tb_subbytes_serial.sv
// Scoreboard bench for subbytes_serial: acceptances push expected results,
// a negedge monitor pops and compares whenever a result is handed off.
module tb_subbytes_serial;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] S63 = {16{8'h63}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] state_in = '0;
  logic         encrypt = 1'b1;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] state_out;
  logic         busy;

  subbytes_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .encrypt   (encrypt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int n_results = 0;
  logic [127:0] exp_next = '0;

  typedef struct {
    logic [127:0] data;
    int           acc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", name, act, want);
    end
  endtask

  // Acceptance monitor: the handshake completes on the following rising edge.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) sb.push_back('{data: exp_next, acc: cyc + 1});
  end

  logic         prev_valid = 1'b0;
  logic [127:0] prev_out = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid && sb.size() > 0)
        chk("latency", 128'(cyc - sb[0].acc), 128'(16));
      if (out_valid && prev_valid) begin
        chk("state_out hold", state_out, prev_out);
        chk("in_ready while done", 128'(in_ready), 128'(0));
      end
      if (out_valid && out_ready) begin
        n_results++;
        if (sb.size() == 0) begin
          chk("pending expectations", 128'(sb.size()), 128'(1));
        end else begin
          chk("state_out", state_out, sb[0].data);
          void'(sb.pop_front());
        end
      end
      prev_valid = out_valid;
      prev_out   = state_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] d, input logic enc, input logic [127:0] e);
    state_in = d;
    encrypt  = enc;
    exp_next = e;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("accept ready", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n);
    for (int i = 0; i < 200 && n_results < n; i++) tick();
    chk("result count", 128'(n_results), 128'(n));
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst in_ready", 128'(in_ready), 128'(1));
    chk("rst out_valid", 128'(out_valid), 128'(0));
    chk("rst busy", 128'(busy), 128'(0));
    chk("rst state_out", state_out, 128'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // Forward and inverse
    send(PT, 1'b1, CT);
    wait_results(1);
    send(CT, 1'b0, PT);
    wait_results(2);

    // Backpressure
    out_ready = 1'b0;
    send(PT, 1'b1, CT);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("bp out_valid", 128'(out_valid), 128'(1));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp valid held", 128'(out_valid), 128'(1));
      chk("bp in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    tick();
    chk("bp idle in_ready", 128'(in_ready), 128'(1));
    chk("bp idle out_valid", 128'(out_valid), 128'(0));
    chk("bp idle busy", 128'(busy), 128'(0));
    wait_results(3);

    // Disturbance during RUN
    send('0, 1'b1, S63);
    for (int i = 0; i < 10; i++) begin
      tick();
      encrypt  = ~encrypt;
      state_in = {$urandom, $urandom, $urandom, $urandom};
      exp_next = state_in;
      in_valid = i[0];
    end
    in_valid = 1'b0;
    wait_results(4);
    for (int i = 0; i < 20; i++) tick();
    chk("single result", 128'(n_results), 128'(4));

    // Reset mid-run at cnt==7
    send(PT, 1'b1, CT);
    for (int i = 0; i < 7; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", 128'(out_valid), 128'(0));
    chk("abort busy", 128'(busy), 128'(0));
    chk("abort in_ready", 128'(in_ready), 128'(1));
    chk("abort state_out", state_out, 128'(0));
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    send(PT, 1'b1, CT);
    wait_results(5);

    // Back-to-back with in_valid held high
    state_in = PT;
    encrypt  = 1'b1;
    exp_next = CT;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    tick();
    state_in = CT;
    encrypt  = 1'b0;
    exp_next = PT;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) break;
    end
    chk("b2b first done", 128'(out_valid), 128'(1));
    tick();
    @(negedge clk);
    chk("b2b ready after handshake", 128'(in_ready), 128'(1));
    tick();
    chk("b2b second accepted", 128'(busy), 128'(1));
    in_valid = 1'b0;
    wait_results(7);

    chk("scoreboard empty", 128'(sb.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
